// File: rtl/miriscv_data_arb_pkg.sv
// Shared definitions for the two-master data-port arbiter: owner encoding,
// FSM state type, the burst counter width and the default burst limit.
package miriscv_data_arb_pkg;

  // Owner encoding; the FSM state values reuse these codes directly.
  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_M0   = 2'd1;
  localparam logic [1:0] OWN_M1   = 2'd2;

  // Default number of back-to-back wins allowed while the other master waits.
  localparam int unsigned DEF_MAX_BURST = 4;

  // Counter width covers the legal burst range 1..15 (count tops out at 14).
  localparam int unsigned BCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = OWN_IDLE,
    ST_OWN_M0 = OWN_M0,
    ST_OWN_M1 = OWN_M1
  } arb_state_e;

  // Ownership state for a master index (0 = M0, 1 = M1).
  function automatic arb_state_e owner_state(input logic idx);
    return idx ? ST_OWN_M1 : ST_OWN_M0;
  endfunction

endpackage

// File: rtl/miriscv_data_arb_rr_arb2.sv
// Combinational grant logic: round-robin between two masters with a bounded
// burst hold for the current owner while the other master is also waiting.
module miriscv_rr_arb2
  import miriscv_data_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic              req0_i,
  input  logic              req1_i,
  input  arb_state_e        state_i,
  input  logic              last_owner_i,
  input  logic [BCNT_W-1:0] burst_cnt_i,
  output logic              gnt0_o,
  output logic              gnt1_o
);

  localparam logic [BCNT_W-1:0] CNT_MAX = BCNT_W'(MAX_BURST - 1);

  logic hold_ok;

  // The owner may keep the port only while its burst count is below the limit.
  assign hold_ok = (burst_cnt_i < CNT_MAX);

  // Grant selection; the tie-break hands the port to the non-last owner.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (req0_i && req1_i) begin
      if ((state_i == ST_OWN_M0) && hold_ok) begin
        gnt0_o = 1'b1;
      end else if ((state_i == ST_OWN_M1) && hold_ok) begin
        gnt1_o = 1'b1;
      end else if (last_owner_i) begin
        gnt0_o = 1'b1;
      end else begin
        gnt1_o = 1'b1;
      end
    end else if (req0_i) begin
      gnt0_o = 1'b1;
    end else if (req1_i) begin
      gnt1_o = 1'b1;
    end
  end

endmodule

// File: rtl/miriscv_data_arb.sv
// Two-master arbiter sharing the single data port of miriscv_ram.
// M0 is the core LSU, M1 a secondary master (loader / DMA). Holds the
// ownership FSM, burst counter, payload mux and response routing.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no transfer accepted in the previous cycle
// ST_OWN_M0  | M0 owned the most recent accepted transfer
// ST_OWN_M1  | M1 owned the most recent accepted transfer
module miriscv_data_arb
  import miriscv_data_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic                clk_i,
  input  logic                rst_n_i,

  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,

  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,

  output logic                s_req_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_be_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic [DATA_W-1:0]   s_rdata_i
);

  localparam logic [BCNT_W-1:0] CNT_MAX = BCNT_W'(MAX_BURST - 1);

  arb_state_e        state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic              rsp_pend_q;
  logic              rsp_owner_q;

  logic              gnt0, gnt1;
  logic              any_gnt;
  arb_state_e        win_state;

  miriscv_rr_arb2 #(
    .MAX_BURST (MAX_BURST)
  ) u_rr_arb2 (
    .req0_i       (m0_req_i),
    .req1_i       (m1_req_i),
    .state_i      (state_q),
    .last_owner_i (last_owner_q),
    .burst_cnt_i  (burst_cnt_q),
    .gnt0_o       (gnt0),
    .gnt1_o       (gnt1)
  );

  assign any_gnt   = gnt0 | gnt1;
  assign win_state = owner_state(gnt1);

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;
  assign s_req_o  = any_gnt;

  // Ownership FSM register; last_owner resets to M1 so M0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  // Next ownership and burst count; the count restarts on an owner change and
  // saturates at the limit so continued solo requests never wrap it.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    if (any_gnt) begin
      state_d      = win_state;
      last_owner_d = gnt1;
      if (state_q == win_state) begin
        if (burst_cnt_q >= CNT_MAX) begin
          burst_cnt_d = CNT_MAX;
        end else begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end else begin
        burst_cnt_d = '0;
      end
    end else begin
      state_d     = ST_IDLE;
      burst_cnt_d = '0;
    end
  end

  // Payload mux toward the RAM; everything is driven to zero when idle.
  always_comb begin
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    if (gnt0) begin
      s_we_o    = m0_we_i;
      s_be_o    = m0_be_i;
      s_addr_o  = m0_addr_i;
      s_wdata_o = m0_wdata_i;
    end else if (gnt1) begin
      s_we_o    = m1_we_i;
      s_be_o    = m1_be_i;
      s_addr_o  = m1_addr_i;
      s_wdata_o = m1_wdata_i;
    end
  end

  // Remember who issued the accepted access so its response is routed back;
  // the async clear drops any in-flight response on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= 1'b0;
    end else begin
      rsp_pend_q  <= any_gnt;
      rsp_owner_q <= gnt1;
    end
  end

  assign m0_rvalid_o = rsp_pend_q & ~rsp_owner_q;
  assign m1_rvalid_o = rsp_pend_q &  rsp_owner_q;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

endmodule

// File: tb/tb_miriscv_data_arb.sv
// Directed bench for miriscv_data_arb with a small word RAM model behind
// the slave port (read data one cycle after an accepted request).
module tb_miriscv_data_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata, s_rdata;

  logic [31:0] mem [0:63];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  miriscv_data_arb dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .m0_req_i    (m0_req),
    .m0_we_i     (m0_we),
    .m0_be_i     (m0_be),
    .m0_addr_i   (m0_addr),
    .m0_wdata_i  (m0_wdata),
    .m0_gnt_o    (m0_gnt),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_we_i     (m1_we),
    .m1_be_i     (m1_be),
    .m1_addr_i   (m1_addr),
    .m1_wdata_i  (m1_wdata),
    .m1_gnt_o    (m1_gnt),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .s_req_o     (s_req),
    .s_we_o      (s_we),
    .s_be_o      (s_be),
    .s_addr_o    (s_addr),
    .s_wdata_o   (s_wdata),
    .s_rdata_i   (s_rdata)
  );

  // RAM model: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (s_req) begin
      if (s_we) begin
        for (int b = 0; b < 4; b++)
          if (s_be[b]) mem[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      end
      s_rdata <= mem[s_addr[7:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_be = 4'h0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_be = 4'h0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // Advance to the next sampling window (after negedge, away from posedge).
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4'h4]  = 32'hDEADBEEF;   // 0x10
    mem[4'hC]  = 32'h11223344;   // 0x30
    s_rdata = '0;
    idle_inputs();
    rst_n = 0;

    // Reset state
    #2;
    chk("rst_m0_gnt",    m0_gnt,    0);
    chk("rst_m1_gnt",    m1_gnt,    0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_s_req",     s_req,     0);
    @(negedge clk);
    rst_n = 1;

    // M0 only read of 0x10
    step();
    m0_req = 1; m0_addr = 32'h10;
    #1;
    chk("m0rd_gnt",    m0_gnt, 1);
    chk("m0rd_m1gnt",  m1_gnt, 0);
    chk("m0rd_s_req",  s_req,  1);
    chk("m0rd_s_addr", s_addr, 32'h10);
    chk("m0rd_s_we",   s_we,   0);
    step();
    m0_req = 0; m0_addr = '0;
    #1;
    chk("m0rd_rvalid",   m0_rvalid, 1);
    chk("m0rd_rdata",    m0_rdata,  32'hDEADBEEF);
    chk("m0rd_m1rvalid", m1_rvalid, 0);
    chk("idle_s_req",    s_req,     0);
    chk("idle_s_addr",   s_addr,    0);

    // First tie after reset goes to M0, then M1
    do_reset();
    step();
    m0_req = 1; m0_addr = 32'h10;
    m1_req = 1; m1_addr = 32'h20;
    #1;
    chk("tie_m0_gnt", m0_gnt, 1);
    chk("tie_m1_gnt", m1_gnt, 0);
    chk("tie_s_addr", s_addr, 32'h10);
    step();
    m0_req = 0;
    #1;
    chk("tie2_m1_gnt",    m1_gnt,    1);
    chk("tie2_m0_gnt",    m0_gnt,    0);
    chk("tie2_s_addr",    s_addr,    32'h20);
    chk("tie2_m0_rvalid", m0_rvalid, 1);
    chk("tie2_m1_rvalid", m1_rvalid, 0);
    step();
    m1_req = 0;
    #1;
    chk("tie3_m1_rvalid", m1_rvalid, 1);
    chk("tie3_m0_rvalid", m0_rvalid, 0);

    // Sustained contention, 16 cycles: M0x4, M1x4, M0x4, M1x4
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      step();
      if (i < 16) begin
        m0_req = 1; m0_addr = 32'h10;
        m1_req = 1; m1_addr = 32'h20;
      end else begin
        m0_req = 0; m1_req = 0;
      end
      #1;
      if (i < 16) begin
        chk($sformatf("burst%0d_m0_gnt", i), m0_gnt, ((i / 4) % 2) == 0);
        chk($sformatf("burst%0d_m1_gnt", i), m1_gnt, ((i / 4) % 2) == 1);
        chk($sformatf("burst%0d_s_req", i),  s_req,  1);
      end
      if (i > 0) begin
        chk($sformatf("burst%0d_m0_rvalid", i), m0_rvalid, (((i - 1) / 4) % 2) == 0);
        chk($sformatf("burst%0d_m1_rvalid", i), m1_rvalid, (((i - 1) / 4) % 2) == 1);
      end
    end

    // M1 full write of 0x20, then M0 reads it back
    step();
    m1_req = 1; m1_we = 1; m1_be = 4'hF; m1_addr = 32'h20; m1_wdata = 32'h55AA00FF;
    #1;
    chk("wr_m1_gnt",   m1_gnt,    1);
    chk("wr_s_we",     s_we,      1);
    chk("wr_s_be",     s_be,      4'hF);
    chk("wr_s_wdata",  s_wdata,   32'h55AA00FF);
    step();
    idle_inputs();
    m0_req = 1; m0_addr = 32'h20;
    #1;
    chk("wr_m1_rvalid", m1_rvalid, 1);
    chk("rd_m0_gnt",    m0_gnt,    1);
    chk("rd_s_we",      s_we,      0);
    step();
    m0_req = 0;
    #1;
    chk("rd_m0_rvalid", m0_rvalid, 1);
    chk("rd_m0_rdata",  m0_rdata,  32'h55AA00FF);

    // Partial write: byte 1 of 0x30
    step();
    m1_req = 1; m1_we = 1; m1_be = 4'b0010; m1_addr = 32'h30; m1_wdata = 32'h0000AB00;
    #1;
    chk("pw_s_be", s_be, 4'b0010);
    step();
    idle_inputs();
    m0_req = 1; m0_addr = 32'h30;
    #1;
    chk("pw_m1_rvalid", m1_rvalid, 1);
    step();
    m0_req = 0;
    #1;
    chk("pw_rdata", m0_rdata, 32'h1122AB44);

    // Async reset with a response pending
    step();
    m0_req = 1; m0_addr = 32'h10;
    #1;
    chk("ar_m0_gnt", m0_gnt, 1);
    step();
    m0_req = 0;
    #1;
    chk("ar_pend_rvalid", m0_rvalid, 1);
    #1;
    rst_n = 0;
    #1;
    chk("ar_m0_rvalid_drop", m0_rvalid, 0);
    chk("ar_m1_rvalid_drop", m1_rvalid, 0);
    step();
    rst_n = 1;
    step();
    m0_req = 1; m0_addr = 32'h10;
    m1_req = 1; m1_addr = 32'h20;
    #1;
    chk("ar_tie_m0_gnt", m0_gnt, 1);
    chk("ar_tie_m1_gnt", m1_gnt, 0);
    step();
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/miriscv_data_arb.md
Name: miriscv_data_arb

Overview:
- Two-master arbiter that shares the single data port of miriscv_ram. Master 0 is the core LSU; master 1 is a secondary bus master such as a program loader or DMA.
- Sits in miriscv_top between the core data signals and the RAM data port, replacing the direct wire-through.
- Arbitration is round-robin with a bounded burst hold.
- Read data returns one cycle after an accepted read and is routed back to the issuing master.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_BURST, 4, maximum consecutive accepted transfers one master may win while the other master is requesting; legal range 1..15.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- m0_req_i / m1_req_i  in  1  transfer request
- m0_we_i / m1_we_i  in  1  write enable (1 = write)
- m0_be_i / m1_be_i  in  DATA_W/8  byte enables
- m0_addr_i / m1_addr_i  in  ADDR_W  byte address
- m0_wdata_i / m1_wdata_i  in  DATA_W  write data
- m0_gnt_o / m1_gnt_o  out  1  request accepted this cycle
- m0_rvalid_o / m1_rvalid_o  out  1  response valid, one cycle after an accepted transfer
- m0_rdata_o / m1_rdata_o  out  DATA_W  read data; valid when rvalid=1
- s_req_o  out  1  request to RAM
- s_we_o  out  1  write enable to RAM
- s_be_o  out  DATA_W/8  byte enables to RAM
- s_addr_o  out  ADDR_W  address to RAM
- s_wdata_o  out  DATA_W  write data to RAM
- s_rdata_i  in  DATA_W  RAM read data; valid the cycle after s_req_o=1

Behaviour:
- Clock and reset: single clock clk_i; reset rst_n_i is asynchronous and active-low.
- Reset values:
  - state = IDLE, last_owner = M1 (so M0 wins the first tie), burst_cnt = 0.
  - rsp_pend = 0, rsp_owner = 0.
  - All gnt and rvalid outputs = 0; s_req_o = 0.
- FSM states: IDLE, OWN_M0, OWN_M1. The state holds the owner of the most recent accepted transfer.
- Grant is combinational, computed from current requests and registered state:
  - Only one master requests: it is granted.
  - Both request, state = OWN_Mx, and burst_cnt < MAX_BURST-1: Mx is granted (burst hold).
  - Both request, burst exhausted or state = IDLE: the master not equal to last_owner is granted.
  - Neither requests: no grant; s_req_o = 0.
- At most one gnt is high per cycle. The slave mux selects the granted master's we/be/addr/wdata. s_req_o = OR of grants.
- Slave outputs when no grant: s_we_o = 0, s_be_o = 0, s_addr_o = 0, s_wdata_o = 0.
- On accepted transfer by master Mx:
  - state <= OWN_Mx; last_owner <= Mx.
  - burst_cnt <= burst_cnt+1 if the previous owner was Mx, else 0.
  - burst_cnt saturates at MAX_BURST-1.
- No accepted transfer: state <= IDLE, burst_cnt <= 0.
- Burst count when only the owner requests: it keeps counting but never blocks. The limit only matters when the other master also requests.
- Response path:
  - rsp_pend <= s_req_o; rsp_owner <= granted index.
  - Next cycle, mx_rvalid_o = rsp_pend & (rsp_owner == x); mx_rdata_o = s_rdata_i.
  - Writes also produce an rvalid pulse (write acknowledge); rdata is don't-care for writes.
- Back-to-back: a master may issue a new request in the same cycle its previous rvalid is high. Full throughput is 1 transfer/cycle.
- Fairness: with both masters continuously requesting, the grant pattern is MAX_BURST transfers to one master, then MAX_BURST to the other. No starvation beyond MAX_BURST cycles.
- Request lowered without grant: withdrawn, no side effects. Masters must keep req and payload stable until gnt.
- Reset mid-transfer:
  - Asynchronous clear of rsp_pend; no rvalid is issued for the in-flight access.
  - RAM write side effects of an already-accepted write are not undone.
- MAX_BURST = 1 degenerates to strict alternation under contention.

Decomposition:
- Shared package: owner encoding constants (OWN_IDLE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2) and the default MAX_BURST constant.
- One natural sub-module, miriscv_rr_arb2: the combinational grant logic (inputs: two requests, state, last_owner, burst_cnt; outputs: two grants).
- The top module holds the FSM, counter, payload mux and response routing.

Test Plan:
- Reset then M0 only: read addr 0x10 where RAM holds 0xDEADBEEF -> m0_gnt_o=1 same cycle, s_addr_o=0x10; next cycle m0_rvalid_o=1, m0_rdata_o=0xDEADBEEF; m1_rvalid_o=0.
- First tie: both request in the first cycle after reset -> M0 granted (last_owner reset = M1); M1 granted in the next cycle.
- Sustained contention, MAX_BURST=4, both req held 16 cycles -> grants M0×4, M1×4, M0×4, M1×4; no cycle without a grant; rvalid follows each grant by exactly one cycle to the matching master.
- M1 write then M0 read: M1 writes 0x55AA00FF to 0x20 with be=4'b1111; next cycle M0 reads 0x20 -> M1 rvalid in cycle 2; m0_rdata_o=0x55AA00FF in cycle 3.
- Partial write: M1 writes be=4'b0010 with data 0x0000AB00 over 0x11223344 -> subsequent read returns 0x1122AB44.
- Async reset pulse while rsp_pend=1 -> both rvalid outputs drop immediately; state = IDLE; next tie grants M0.
